// File: rtl/puc_job_scheduler_if.sv
// Job request/response and adapter-shape signals between requesters, the
// scheduler and the matrix adapter. Requester k owns bit k and slice [32k+31:32k].
interface puc_job_scheduler_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_in1_rows;
    logic [63:0] req_in1_cols;
    logic [63:0] req_in2_rows;
    logic [63:0] req_in2_cols;

    logic        puc_ena;
    logic        puc_sel;
    logic [31:0] puc_in1_rows;
    logic [31:0] puc_in1_cols;
    logic [31:0] puc_in2_rows;
    logic [31:0] puc_in2_cols;
    logic [31:0] puc_out_rows;
    logic [31:0] puc_out_cols;

    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [1:0]  rsp_ready;

    // Requester/adapter side.
    modport master (
        output req_valid, req_in1_rows, req_in1_cols, req_in2_rows, req_in2_cols,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_err,
        input  puc_ena, puc_sel,
        input  puc_in1_rows, puc_in1_cols, puc_in2_rows, puc_in2_cols,
        input  puc_out_rows, puc_out_cols
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_in1_rows, req_in1_cols, req_in2_rows, req_in2_cols,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_err,
        output puc_ena, puc_sel,
        output puc_in1_rows, puc_in1_cols, puc_in2_rows, puc_in2_cols,
        output puc_out_rows, puc_out_cols
    );
endinterface

// File: rtl/puc_job_scheduler.sv
// Two-requester round-robin job scheduler for a matrix adapter: validates operand
// shapes, issues one enable pulse per legal job, waits LATENCY cycles and responds.
module puc_job_scheduler #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned MAX_ROWS = 32,
    parameter int unsigned MAX_COLS = 32,
    parameter int unsigned LATENCY  = 1
) (
    input  logic                clock,
    input  logic                reset,
    puc_job_scheduler_if.slave  bus,
    output logic                busy,
    output logic [15:0]         job_count
);

    // Data elements never pass through this block; DWIDTH only has to be sane.
    if (DWIDTH == 0 || MAX_ROWS == 0 || MAX_COLS == 0 || LATENCY == 0 || LATENCY > 255)
    begin : g_param_check
        $error("puc_job_scheduler: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  wait_cnt;
    logic        rr_ptr;
    logic        sel_q;
    logic        err_q;
    logic [31:0] in1_rows_q;
    logic [31:0] in1_cols_q;
    logic [31:0] in2_rows_q;
    logic [31:0] in2_cols_q;

    logic        any_req;
    logic        grant;
    logic        take_job;
    logic        rsp_done;
    logic [31:0] g_in1_rows;
    logic [31:0] g_in1_cols;
    logic [31:0] g_in2_rows;
    logic [31:0] g_in2_cols;
    logic        g_illegal;

    assign any_req  = |bus.req_valid;
    assign take_job = (state == IDLE) && any_req;
    assign rsp_done = (state == RESP) && bus.rsp_ready[sel_q];

    // Round-robin pick and shape mux for the candidate requester.
    always_comb begin
        grant      = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        g_in1_rows = grant ? bus.req_in1_rows[63:32] : bus.req_in1_rows[31:0];
        g_in1_cols = grant ? bus.req_in1_cols[63:32] : bus.req_in1_cols[31:0];
        g_in2_rows = grant ? bus.req_in2_rows[63:32] : bus.req_in2_rows[31:0];
        g_in2_cols = grant ? bus.req_in2_cols[63:32] : bus.req_in2_cols[31:0];
    end

    always_comb begin
        g_illegal = 1'b0;
        if (g_in1_rows == 32'd0 || g_in1_cols == 32'd0 ||
            g_in2_rows == 32'd0 || g_in2_cols == 32'd0) begin
            g_illegal = 1'b1;
        end
        if (g_in1_rows > 32'(MAX_ROWS) || g_in2_rows > 32'(MAX_ROWS)) begin
            g_illegal = 1'b1;
        end
        if (g_in1_cols > 32'(MAX_COLS) || g_in2_cols > 32'(MAX_COLS)) begin
            g_illegal = 1'b1;
        end
        if (g_in1_cols != g_in2_rows) begin
            g_illegal = 1'b1;
        end
    end

    // State register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = g_illegal ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt <= 8'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready[sel_q]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, latched shapes, latency counter and completion count.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr     <= 1'b0;
            sel_q      <= 1'b0;
            err_q      <= 1'b0;
            in1_rows_q <= 32'd0;
            in1_cols_q <= 32'd0;
            in2_rows_q <= 32'd0;
            in2_cols_q <= 32'd0;
            wait_cnt   <= 8'd0;
            job_count  <= 16'd0;
        end else begin
            if (take_job) begin
                rr_ptr     <= ~grant;
                sel_q      <= grant;
                err_q      <= g_illegal;
                in1_rows_q <= g_in1_rows;
                in1_cols_q <= g_in1_cols;
                in2_rows_q <= g_in2_rows;
                in2_cols_q <= g_in2_cols;
            end

            if (state == ISSUE) begin
                wait_cnt <= 8'(LATENCY);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 8'd1;
            end

            if (rsp_done && !err_q) begin
                job_count <= job_count + 16'd1;
            end
        end
    end

    // Output logic. req_ready is masked during reset so no grant can coincide with it.
    always_comb begin
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        bus.rsp_err   = 1'b0;
        bus.puc_ena   = 1'b0;
        busy          = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req && !reset) begin
                    bus.req_ready[grant] = 1'b1;
                end
            end
            ISSUE: begin
                bus.puc_ena = 1'b1;
            end
            WAIT: begin
                bus.puc_ena = 1'b0;
            end
            RESP: begin
                bus.rsp_valid[sel_q] = 1'b1;
                bus.rsp_err          = err_q;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Shapes and select come straight from the grant-time registers, so they
    // cannot move between one grant and the next.
    assign bus.puc_sel      = sel_q;
    assign bus.puc_in1_rows = in1_rows_q;
    assign bus.puc_in1_cols = in1_cols_q;
    assign bus.puc_in2_rows = in2_rows_q;
    assign bus.puc_in2_cols = in2_cols_q;
    assign bus.puc_out_rows = in1_rows_q;
    assign bus.puc_out_cols = in2_cols_q;

endmodule

// File: tb/tb_puc_job_scheduler.sv
// Directed and randomized checks of puc_job_scheduler against a job-level
// reference model (round-robin order, shape legality, latency, completion count).
module tb_puc_job_scheduler;

    localparam int LAT = 3;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] c1;
        logic [31:0] r2;
        logic [31:0] c2;
    } shape_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] job_count;

    puc_job_scheduler_if bus ();

    puc_job_scheduler #(
        .DWIDTH   (16),
        .MAX_ROWS (32),
        .MAX_COLS (32),
        .LATENCY  (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .job_count (job_count)
    );

    always #5 clock = ~clock;

    int     checks = 0;
    int     passes = 0;
    int     prio = 0;
    int     exp_jobs = 0;
    int     exp_ena = 0;
    int     ena_seen = 0;
    logic [1:0] req_v = 2'b00;
    shape_t job [2];

    always @(negedge clock) begin
        if (bus.puc_ena === 1'b1) ena_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive();
        bus.req_valid    = req_v;
        bus.req_in1_rows = {job[1].r1, job[0].r1};
        bus.req_in1_cols = {job[1].c1, job[0].c1};
        bus.req_in2_rows = {job[1].r2, job[0].r2};
        bus.req_in2_cols = {job[1].c2, job[0].c2};
    endtask

    function automatic bit legal(input shape_t s);
        return s.r1 != 0 && s.c1 != 0 && s.r2 != 0 && s.c2 != 0 &&
               s.r1 <= 32 && s.r2 <= 32 && s.c1 <= 32 && s.c2 <= 32 &&
               s.c1 == s.r2;
    endfunction

    function automatic shape_t rand_shape();
        shape_t s;
        s.r1 = 32'($urandom_range(1, 32));
        s.c1 = 32'($urandom_range(1, 32));
        s.r2 = s.c1;
        s.c2 = 32'($urandom_range(1, 32));
        case ($urandom_range(0, 6))
            1: s.r2 = (s.c1 % 32) + 1;
            2: s.r1 = 32'd33;
            3: s.c2 = 32'd0;
            4: s.r1 = 32'd0;
            5: s.c2 = $urandom | 32'h8000_0000;
            default: ;
        endcase
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_puc_ena"}, bus.puc_ena, 0);
        check({tag, "_puc_sel"}, bus.puc_sel, 0);
        check({tag, "_in1_rows"}, bus.puc_in1_rows, 0);
        check({tag, "_in1_cols"}, bus.puc_in1_cols, 0);
        check({tag, "_in2_rows"}, bus.puc_in2_rows, 0);
        check({tag, "_in2_cols"}, bus.puc_in2_cols, 0);
        check({tag, "_out_rows"}, bus.puc_out_rows, 0);
        check({tag, "_out_cols"}, bus.puc_out_cols, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_job_count"}, job_count, 0);
    endtask

    // Runs one job from the grant cycle (DUT idle, inputs already driven) to
    // the cycle after the response handshake.
    task automatic serve_one(input bit drop, input int rsp_delay, output int granted);
        int         g;
        bit         ok;
        shape_t     s;
        logic [1:0] oh;
        settle();
        g  = req_v[prio] ? prio : 1 - prio;
        oh = 2'(1 << g);
        check("req_ready_grant", bus.req_ready, oh);
        check("busy_idle", busy, 0);
        s       = job[g];
        ok      = legal(s);
        prio    = 1 - g;
        granted = g;
        step();
        if (drop) begin
            req_v[g] = 1'b0;
            drive();
        end
        settle();
        check("puc_sel", bus.puc_sel, g);
        check("puc_out_rows", bus.puc_out_rows, s.r1);
        check("puc_out_cols", bus.puc_out_cols, s.c2);
        check("puc_in_shapes", {bus.puc_in1_cols, bus.puc_in2_rows}, {s.c1, s.r2});
        check("req_ready_busy", bus.req_ready, 0);
        if (ok) begin
            check("puc_ena_issue", bus.puc_ena, 1);
            check("rsp_valid_issue", bus.rsp_valid, 0);
            exp_ena++;
            for (int i = 0; i < LAT; i++) begin
                step();
                check("wait_outputs", {bus.puc_ena, bus.rsp_valid, busy}, {1'b0, 2'b00, 1'b1});
                check("wait_shape_hold", {bus.puc_out_rows, bus.puc_out_cols}, {s.r1, s.c2});
            end
            step();
        end
        check("rsp_valid", bus.rsp_valid, oh);
        check("rsp_err", bus.rsp_err, !ok);
        check("puc_ena_resp", bus.puc_ena, 0);
        for (int i = 0; i < rsp_delay; i++) begin
            bus.rsp_ready = ~oh;
            settle();
            check("hold_rsp", {bus.rsp_valid, bus.rsp_err, busy}, {oh, !ok, 1'b1});
            check("hold_no_grant", bus.req_ready, 0);
            step();
        end
        bus.rsp_ready = oh;
        settle();
        check("handshake_no_grant", bus.req_ready, 0);
        step();
        bus.rsp_ready = 2'b00;
        if (ok) exp_jobs++;
        settle();
        check("job_count", job_count, exp_jobs);
        check("idle_after_rsp", {bus.rsp_valid, busy}, 0);
    endtask

    initial begin
        int g;

        // Reset with both requests raised: nothing may be granted.
        reset          = 1'b1;
        bus.rsp_ready  = 2'b00;
        job[0]         = rand_shape();
        job[1]         = rand_shape();
        req_v          = 2'b11;
        drive();
        step();
        step();
        settle();
        check_reset_outputs("rst");
        req_v = 2'b00;
        drive();
        reset = 1'b0;
        step();
        settle();
        check_reset_outputs("post_rst");

        // 4x8 by 8x2 from requester 0.
        job[0] = '{32'd4, 32'd8, 32'd8, 32'd2};
        req_v  = 2'b01;
        drive();
        serve_one(1'b1, 0, g);
        check("basic_grant", g, 0);
        check("basic_job_count", job_count, 1);

        // Inner-dimension mismatch from requester 1.
        job[1] = '{32'd3, 32'd5, 32'd6, 32'd7};
        req_v  = 2'b10;
        drive();
        serve_one(1'b1, 2, g);
        check("mismatch_grant", g, 1);
        check("mismatch_job_count", job_count, 1);

        // Both requesters valid continuously: grants must alternate.
        job[0] = '{32'd2, 32'd3, 32'd3, 32'd4};
        job[1] = '{32'd32, 32'd32, 32'd32, 32'd32};
        req_v  = 2'b11;
        drive();
        for (int i = 0; i < 4; i++) begin
            serve_one(1'b0, 0, g);
            check("rr_alternate", g, i % 2);
        end
        req_v = 2'b00;
        drive();

        // Dimension 33 and dimension 0.
        job[0] = '{32'd33, 32'd4, 32'd4, 32'd4};
        req_v  = 2'b01;
        drive();
        serve_one(1'b1, 1, g);
        job[1] = '{32'd4, 32'd4, 32'd4, 32'd0};
        req_v  = 2'b10;
        drive();
        serve_one(1'b1, 0, g);

        // Long response stall with the other requester pending.
        job[0] = '{32'd1, 32'd1, 32'd1, 32'd1};
        job[1] = '{32'd5, 32'd6, 32'd6, 32'd7};
        req_v  = 2'b11;
        drive();
        serve_one(1'b1, 10, g);
        check("stall_first", g, 0);
        serve_one(1'b1, 0, g);
        check("stall_second", g, 1);

        // Randomized traffic.
        for (int it = 0; it < 16; it++) begin
            for (int k = 0; k < 2; k++) begin
                if (!req_v[k] && $urandom_range(0, 1) == 1) begin
                    job[k]   = rand_shape();
                    req_v[k] = 1'b1;
                end
            end
            if (req_v == 2'b00) begin
                job[it % 2]   = rand_shape();
                req_v[it % 2] = 1'b1;
            end
            drive();
            serve_one(1'b1, int'($urandom_range(0, 3)), g);
        end
        req_v = 2'b00;
        drive();
        step();

        // Reset during WAIT aborts the job.
        job[0] = '{32'd8, 32'd8, 32'd8, 32'd8};
        req_v  = 2'b01;
        drive();
        settle();
        check("abort_grant", bus.req_ready, 2'b01);
        step();
        req_v = 2'b00;
        drive();
        settle();
        check("abort_issue", bus.puc_ena, 1);
        exp_ena++;
        step();
        step();
        check("abort_in_wait", {bus.puc_ena, bus.rsp_valid, busy}, {1'b0, 2'b00, 1'b1});
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check_reset_outputs("mid_rst");
        prio     = 0;
        exp_jobs = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            check("abort_no_rsp", {bus.rsp_valid, busy, job_count}, 0);
        end

        job[1] = '{32'd6, 32'd2, 32'd2, 32'd9};
        req_v  = 2'b10;
        drive();
        serve_one(1'b1, 1, g);
        check("after_rst_grant", g, 1);
        check("after_rst_job_count", job_count, 1);

        step();
        check("puc_ena_pulses", ena_seen, exp_ena);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
